// File: rtl/cmp_pipe.sv
// Pipelined unsigned comparator: operands split into SEG-bit segments, evaluated LSB-first,
// one segment per stage as a registered eq/lt carry chain. Runtime op select, CE stall, match count.
module cmp_pipe #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SEG   = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             CE,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] I0,
    input  logic [WIDTH-1:0] I1,
    input  logic [1:0]       op,
    output logic             out_valid,
    output logic             O,
    output logic [CNT_W-1:0] match_count
);

    localparam int unsigned NSTAGE = (WIDTH + SEG - 1) / SEG;
    localparam int unsigned PW     = NSTAGE * SEG;

    logic [PW-1:0] a_pad, b_pad;

    always_comb begin
        a_pad = '0;
        b_pad = '0;
        a_pad[WIDTH-1:0] = I0;
        b_pad[WIDTH-1:0] = I1;
    end

    // Per-stage view of the operand segment and of the incoming chain state.
    logic [SEG-1:0] seg_a [NSTAGE];
    logic [SEG-1:0] seg_b [NSTAGE];
    logic           eq_in [NSTAGE];
    logic           lt_in [NSTAGE];
    logic           vld_in[NSTAGE];
    logic [1:0]     op_in [NSTAGE];

    assign seg_a[0]  = a_pad[SEG-1:0];
    assign seg_b[0]  = b_pad[SEG-1:0];
    assign eq_in[0]  = 1'b1;
    assign lt_in[0]  = 1'b0;
    assign vld_in[0] = in_valid;
    assign op_in[0]  = op;

    // Segment j needs j delay registers so it meets its chain at stage j.
    for (genvar j = 1; j < NSTAGE; j++) begin : g_skew
        logic [SEG-1:0] dly_a [j];
        logic [SEG-1:0] dly_b [j];

        always_ff @(posedge CLK) begin
            if (RESET) begin
                for (int d = 0; d < j; d++) begin
                    dly_a[d] <= '0;
                    dly_b[d] <= '0;
                end
            end else if (CE) begin
                dly_a[0] <= a_pad[j*SEG +: SEG];
                dly_b[0] <= b_pad[j*SEG +: SEG];
                for (int d = 1; d < j; d++) begin
                    dly_a[d] <= dly_a[d-1];
                    dly_b[d] <= dly_b[d-1];
                end
            end
        end

        assign seg_a[j] = dly_a[j-1];
        assign seg_b[j] = dly_b[j-1];
    end

    for (genvar i = 0; i < NSTAGE; i++) begin : g_stage
        logic seg_eq, seg_lt, eq_n, lt_n;

        assign seg_eq = (seg_a[i] == seg_b[i]);
        assign seg_lt = (seg_a[i] < seg_b[i]);
        assign eq_n   = eq_in[i] & seg_eq;
        // A higher segment overrides whatever the lower segments decided.
        assign lt_n   = seg_lt | (seg_eq & lt_in[i]);

        if (i < NSTAGE - 1) begin : g_mid
            logic       eq_q, lt_q, vld_q;
            logic [1:0] op_q;

            always_ff @(posedge CLK) begin
                if (RESET) begin
                    eq_q  <= 1'b0;
                    lt_q  <= 1'b0;
                    vld_q <= 1'b0;
                    op_q  <= 2'b00;
                end else if (CE) begin
                    eq_q  <= eq_n;
                    lt_q  <= lt_n;
                    vld_q <= vld_in[i];
                    op_q  <= op_in[i];
                end
            end

            assign eq_in[i+1]  = eq_q;
            assign lt_in[i+1]  = lt_q;
            assign vld_in[i+1] = vld_q;
            assign op_in[i+1]  = op_q;
        end else begin : g_out
            logic res, hit;

            always_comb begin
                res = 1'b0;
                case (op_in[i])
                    2'b00:   res = eq_n;
                    2'b01:   res = ~eq_n;
                    2'b10:   res = lt_n;
                    2'b11:   res = lt_n | eq_n;
                    default: res = 1'b0;
                endcase
            end

            assign hit = vld_in[i] & res;

            always_ff @(posedge CLK) begin
                if (RESET) begin
                    out_valid   <= 1'b0;
                    O           <= 1'b0;
                    match_count <= '0;
                end else if (CE) begin
                    out_valid <= vld_in[i];
                    O         <= hit;
                    if (hit && (match_count != {CNT_W{1'b1}})) begin
                        match_count <= match_count + CNT_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_cmp_pipe.sv
// Directed bench for cmp_pipe: default 16/4/8 instance plus a 5/2/3 instance for padding
// and counter saturation.
module tb_cmp_pipe;

    logic        CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Default-parameter DUT
    logic        RESET, CE, in_valid;
    logic [15:0] I0, I1;
    logic [1:0]  op;
    logic        out_valid, O;
    logic [7:0]  match_count;

    // Small DUT: WIDTH=5, SEG=2, CNT_W=3
    logic        RESET2, CE2, in_valid2;
    logic [4:0]  I0_2, I1_2;
    logic [1:0]  op2;
    logic        out_valid2, O2;
    logic [2:0]  match_count2;

    int vectors   = 0;
    int miscompares = 0;

    localparam logic [1:0] EQ = 2'b00, NE = 2'b01, ULT = 2'b10, ULE = 2'b11;

    cmp_pipe #(.WIDTH(16), .SEG(4), .CNT_W(8)) dut (
        .CLK(CLK), .RESET(RESET), .CE(CE), .in_valid(in_valid), .I0(I0), .I1(I1), .op(op),
        .out_valid(out_valid), .O(O), .match_count(match_count)
    );

    cmp_pipe #(.WIDTH(5), .SEG(2), .CNT_W(3)) dut2 (
        .CLK(CLK), .RESET(RESET2), .CE(CE2), .in_valid(in_valid2), .I0(I0_2), .I1(I1_2),
        .op(op2), .out_valid(out_valid2), .O(O2), .match_count(match_count2)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic v, input logic [1:0] o, input logic [15:0] a,
                        input logic [15:0] b);
        in_valid = v;
        op       = o;
        I0       = a;
        I1       = b;
        tick();
    endtask

    task automatic bubble();
        push(1'b0, EQ, 16'h0000, 16'h0000);
    endtask

    task automatic check_out(input string tag, input logic v, input logic o,
                             input logic [7:0] cnt);
        check({tag, ".valid"}, {31'd0, out_valid}, {31'd0, v});
        check({tag, ".O"}, {31'd0, O}, {31'd0, o});
        check({tag, ".count"}, {24'd0, match_count}, {24'd0, cnt});
    endtask

    initial begin
        RESET = 1'b1; CE = 1'b1; in_valid = 1'b1; op = EQ; I0 = '0; I1 = '0;
        RESET2 = 1'b1; CE2 = 1'b1; in_valid2 = 1'b0; op2 = EQ; I0_2 = '0; I1_2 = '0;

        // Reset with live random traffic
        for (int c = 0; c < 2; c++) begin
            op = 2'($urandom_range(0, 3));
            I0 = 16'($urandom);
            I1 = 16'($urandom);
            tick();
            check_out("reset", 1'b0, 1'b0, 8'd0);
        end
        RESET = 1'b0;
        RESET2 = 1'b0;

        // Back-to-back requests
        push(1'b1, EQ,  16'hA5A5, 16'hA5A5);
        push(1'b1, ULT, 16'h1234, 16'h1235);
        push(1'b1, ULE, 16'hFFFF, 16'h0000);
        push(1'b1, NE,  16'h0001, 16'h0001);
        check_out("b2b0", 1'b1, 1'b1, 8'd1);
        bubble(); check_out("b2b1", 1'b1, 1'b1, 8'd2);
        bubble(); check_out("b2b2", 1'b1, 1'b0, 8'd2);
        bubble(); check_out("b2b3", 1'b1, 1'b0, 8'd2);
        bubble(); check_out("b2b_drain", 1'b0, 1'b0, 8'd2);

        // Cross-segment borrow and equality
        push(1'b1, ULT, 16'h0FFF, 16'h1000);
        push(1'b1, ULT, 16'h1000, 16'h0FFF);
        push(1'b1, ULE, 16'h8000, 16'h8000);
        bubble(); check_out("xseg0", 1'b1, 1'b1, 8'd3);
        bubble(); check_out("xseg1", 1'b1, 1'b0, 8'd3);
        bubble(); check_out("xseg2", 1'b1, 1'b1, 8'd4);
        bubble(); check_out("xseg_drain", 1'b0, 1'b0, 8'd4);

        // Stall with three requests in flight; inputs during stall are garbage
        push(1'b1, EQ,  16'h0000, 16'h0000);
        push(1'b1, ULT, 16'h0002, 16'h0001);
        push(1'b1, NE,  16'h1234, 16'h4321);
        CE = 1'b0;
        for (int c = 0; c < 3; c++) begin
            push(1'b1, NE, 16'($urandom), 16'($urandom));
            check_out("stall", 1'b0, 1'b0, 8'd4);
        end
        CE = 1'b1;
        bubble(); check_out("stall_r0", 1'b1, 1'b1, 8'd5);
        bubble(); check_out("stall_r1", 1'b1, 1'b0, 8'd5);
        bubble(); check_out("stall_r2", 1'b1, 1'b1, 8'd6);
        bubble(); check_out("stall_drain", 1'b0, 1'b0, 8'd6);

        // Stall while a result is visible: output must hold
        push(1'b1, EQ, 16'h7777, 16'h7777);
        bubble(); bubble(); bubble();
        check_out("hold_pre", 1'b1, 1'b1, 8'd7);
        CE = 1'b0;
        push(1'b0, EQ, 16'h0, 16'h0);
        check_out("hold", 1'b1, 1'b1, 8'd7);
        CE = 1'b1;
        bubble(); check_out("hold_post", 1'b0, 1'b0, 8'd7);

        // Reset mid-flight
        push(1'b1, EQ, 16'h1111, 16'h1111);
        push(1'b1, EQ, 16'h2222, 16'h2222);
        push(1'b1, EQ, 16'h3333, 16'h3333);
        RESET = 1'b1;
        push(1'b1, EQ, 16'h4444, 16'h4444);
        RESET = 1'b0;
        check_out("rst_mid", 1'b0, 1'b0, 8'd0);
        for (int c = 0; c < 4; c++) begin
            bubble();
            check_out("rst_after", 1'b0, 1'b0, 8'd0);
        end

        // Small instance: padding and counter saturation, latency 3
        for (int i = 0; i < 13; i++) begin
            in_valid2 = (i < 10);
            op2       = (i == 9) ? ULT : EQ;
            I0_2      = (i == 9) ? 5'h0F : 5'h1F;
            I1_2      = (i == 9) ? 5'h10 : 5'h1F;
            tick();
            if (i >= 2 && i <= 11) begin
                check("sat.valid", {31'd0, out_valid2}, 32'd1);
                check("sat.O", {31'd0, O2}, 32'd1);
                check("sat.count", {29'd0, match_count2}, (i - 1 > 7) ? 32'd7 : 32'(i - 1));
            end else begin
                check("sat.idle", {31'd0, out_valid2}, 32'd0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
